snd_dma_sequencer: RTL and testbench
====================================

Name: snd_dma_sequencer

Overview:
Sound DMA sequencer for the MCU sound path. It holds the sound frame start and end registers, runs the sound address counter, and issues fetch requests into the sound DMA slots that the bus control logic grants. It buffers the fetched words in a 4-word FIFO and delivers samples to the DAC side on sample-rate ticks. It also produces the end-of-frame interrupt pulse, the frame-repeat reload and the stop indication.

Parameters:
FIFO_DEPTH, 4, FIFO depth in 16-bit words; must be a power of two, at least 2.
AW, 21, MSB index of the word address; the counter and registers cover bits [AW:1].

Ports:
clk32  in  1  single system clock; all state updates on its rising edge
porb  in  1  reset, asynchronous, active-low
reg_we  in  1  register write strobe, one clk32 cycle
reg_addr  in  4  register select: 0 ctrl, 1-3 start hi/mid/lo, 4-6 counter hi/mid/lo (read-only), 7-9 end hi/mid/lo
reg_din  in  8  register write data
reg_dout  out  8  register read data, combinational from reg_addr
dma_ack  in  1  one-cycle pulse: the granted sound slot returned a word this cycle
dma_data  in  16  fetched word, valid with dma_ack
sample_tick  in  1  one-cycle sample-rate strobe
sreq  out  1  sound fetch request to slot logic
snd_addr  out  AW  current sound word address [AW:1] (counter)
sndon  out  1  ctrl bit0 readback / playback enabled
stoff  out  1  high while no frame is being fetched
sint  out  1  end-of-frame pulse, one clk32 cycle
sample_l  out  8  left (or mono) sample
sample_r  out  8  right sample (equals sample_l in mono)

Behaviour:
- Reset (porb low, async): all registers 0, FIFO empty, state IDLE, sreq=0, sint=0, stoff=1, sample_l/r=0, snd_addr=0.
- Ctrl register: bit0 sndon, bit1 repeat, bit2 stereo. Reads return {5'b0, stereo, repeat, sndon}. Address registers: hi byte = bits[21:16] (upper 2 bits of the byte read 0), mid = [15:8], lo = [7:1] in byte bits 7:1, byte bit0 reads 0.
- States:
  - IDLE -> ARM when sndon goes 0->1 via a write.
  - ARM (1 cycle): counter<=start, end_lat<=end. If start>=end: sint pulse, sndon cleared, -> IDLE (repeat ignored). Otherwise -> RUN.
  - RUN: on dma_ack, push the word and counter+=1. When the incremented counter equals end_lat: sint pulses the next cycle; if repeat=1, reload counter/end_lat from the current start/end registers and stay in RUN (no gap); else -> DRAIN.
  - DRAIN: no fetches; when FIFO is empty, sndon<=0 -> IDLE.
- sreq = (state==RUN) & FIFO free words >= 2. Two free words are needed because one ack may be in flight after sreq falls.
- stoff = (state is IDLE or DRAIN), registered.
- sndon written 0 in any state: next cycle -> IDLE, FIFO flushed, sreq=0; a dma_ack arriving while not in RUN is dropped.
- Writes to start/end during RUN take effect at the next frame reload only. Counter bytes are read-only; writes to them are ignored.
- dma_ack with the FIFO full (protocol violation): word dropped, counter still increments.
- Playback:
  - Mono: each sample_tick outputs the next byte, high byte first, then low byte; the word is popped after its low byte. sample_l=sample_r=byte.
  - Stereo: each tick pops one word, sample_l=high byte, sample_r=low byte.
  - Underrun (FIFO empty on tick): outputs hold.
  - A push and a pop in the same cycle are both honoured.
- Counter wraps modulo 2^AW silently.

Decomposition:
- Package snd_dma_pkg: register address constants, ctrl bit positions, state enum {IDLE, ARM, RUN, DRAIN}.
- Sub-module snd_fifo: synchronous FIFO with clk32/porb, a flush input, and push/pop/full/empty/level outputs.

Test Plan:
- Frame: start=0x000100, end=0x000104, ctrl=0x01, ack every 4 cycles -> 4 acks, snd_addr 0x100..0x104, sint one pulse after the 4th ack, DRAIN then IDLE, sndon reads 0.
- Repeat: same setup with ctrl=0x03 and 10 acks -> sint after acks 4 and 8, snd_addr after ack 10 = 0x102, stoff stays 0.
- Empty frame: start=end=0x200, ctrl=0x01 -> sint one cycle after ARM, zero sreq cycles, ctrl reads 0x00.
- FIFO backpressure: no sample_tick, acks on request -> sreq drops with level=FIFO_DEPTH-1; one more ack fills it; 4 words total, no loss.
- Mono/stereo: FIFO holds 0xA1B2 -> mono ticks give 0xA1 then 0xB2; stereo tick gives l=0xA1, r=0xB2; a tick on empty FIFO holds the values.
- Abort: write ctrl=0 mid-RUN with an ack in the same cycle -> IDLE next cycle, FIFO empty, sreq=0, counter frozen, later acks ignored.

Source files
------------

// File: rtl/snd_dma_pkg.sv
// Register map, control-register layout and FSM state type for the sound DMA sequencer.
package snd_dma_pkg;

    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_START_HI  = 4'd1;
    localparam logic [3:0] REG_START_MID = 4'd2;
    localparam logic [3:0] REG_START_LO  = 4'd3;
    localparam logic [3:0] REG_CNT_HI    = 4'd4;
    localparam logic [3:0] REG_CNT_MID   = 4'd5;
    localparam logic [3:0] REG_CNT_LO    = 4'd6;
    localparam logic [3:0] REG_END_HI    = 4'd7;
    localparam logic [3:0] REG_END_MID   = 4'd8;
    localparam logic [3:0] REG_END_LO    = 4'd9;

    // Bit order matches the ctrl byte: bit2 stereo, bit1 repeat, bit0 sndon.
    typedef struct packed {
        logic stereo;
        logic rpt;
        logic sndon;
    } snd_ctrl_t;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} snd_state_e;

    typedef enum logic [1:0] {POS_HI, POS_MID, POS_LO, POS_NONE} byte_pos_e;

    function automatic byte_pos_e reg_pos(input logic [3:0] addr);
        case (addr)
            REG_START_HI, REG_CNT_HI, REG_END_HI:    return POS_HI;
            REG_START_MID, REG_CNT_MID, REG_END_MID: return POS_MID;
            REG_START_LO, REG_CNT_LO, REG_END_LO:    return POS_LO;
            default:                                 return POS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/snd_fifo.sv
// Synchronous word FIFO with flush; push when full and pop when empty are ignored.
module snd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16
) (
    input  logic                     i_clk32,
    input  logic                     i_porb,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_wdata,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk32 or negedge i_porb) begin
        if (!i_porb) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk32) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/snd_dma_sequencer.sv
// Sound DMA sequencer: frame registers, address counter, fetch requests,
// sample FIFO and sample-rate playback to the DAC side.
module snd_dma_sequencer
    import snd_dma_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 21
) (
    input  logic          i_clk32,
    input  logic          i_porb,
    input  logic          i_reg_we,
    input  logic [3:0]    i_reg_addr,
    input  logic [7:0]    i_reg_din,
    output logic [7:0]    o_reg_dout,
    input  logic          i_dma_ack,
    input  logic [15:0]   i_dma_data,
    input  logic          i_sample_tick,
    output logic          o_sreq,
    output logic [AW:1]   o_snd_addr,
    output logic          o_sndon,
    output logic          o_stoff,
    output logic          o_sint,
    output logic [7:0]    o_sample_l,
    output logic [7:0]    o_sample_r
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    snd_state_e  r_state;
    snd_state_e  w_state_d;
    snd_ctrl_t   r_ctrl;
    logic [AW:1] r_start;
    logic [AW:1] r_end;
    logic [AW:1] r_cnt;
    logic [AW:1] r_end_lat;
    logic [AW:1] w_cnt_inc;
    logic [AW:1] w_rd_word;
    logic        r_sint;
    logic        r_stoff;
    logic        w_stoff_d;
    logic        w_sreq;
    logic        r_lo_next;
    logic [7:0]  r_sample_l;
    logic [7:0]  r_sample_r;
    byte_pos_e   w_pos;
    logic        w_in_start;
    logic        w_in_cnt;
    logic        w_in_end;
    logic        w_wr_ctrl;
    logic        w_start_req;
    logic        w_abort;
    logic        w_ack_run;
    logic        w_frame_end;
    logic        w_empty_frame;
    logic        w_sndon_clr;
    logic        w_push;
    logic        w_tick;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [LW-1:0] w_fifo_level;
    logic [15:0] w_fifo_rdata;

    assign w_pos       = reg_pos(i_reg_addr);
    assign w_in_start  = (i_reg_addr >= REG_START_HI) && (i_reg_addr <= REG_START_LO);
    assign w_in_cnt    = (i_reg_addr >= REG_CNT_HI) && (i_reg_addr <= REG_CNT_LO);
    assign w_in_end    = (i_reg_addr >= REG_END_HI) && (i_reg_addr <= REG_END_LO);
    assign w_wr_ctrl   = i_reg_we && (i_reg_addr == REG_CTRL);
    assign w_start_req = w_wr_ctrl && i_reg_din[0] && !r_ctrl.sndon;
    assign w_abort     = w_wr_ctrl && !i_reg_din[0];

    // An abort in the same cycle as an ack wins: the word is dropped and the counter holds.
    assign w_ack_run     = i_dma_ack && (r_state == RUN) && !w_abort;
    assign w_cnt_inc     = r_cnt + AW'(1);
    assign w_frame_end   = w_ack_run && (w_cnt_inc == r_end_lat);
    assign w_empty_frame = (r_state == ARM) && (r_start >= r_end) && !w_abort;
    assign w_sndon_clr   = w_empty_frame || ((r_state == DRAIN) && w_fifo_empty && !w_abort);
    assign w_push        = w_ack_run && !w_fifo_full;

    assign w_tick = i_sample_tick && !w_fifo_empty && !w_abort;
    assign w_pop  = w_tick && (r_ctrl.stereo || r_lo_next);

    always_ff @(posedge i_clk32 or negedge i_porb) begin
        if (!i_porb) r_state <= IDLE;
        else         r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        if (w_abort) begin
            w_state_d = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start_req) w_state_d = ARM;
                ARM:     w_state_d = w_empty_frame ? IDLE : RUN;
                RUN:     if (w_frame_end && !r_ctrl.rpt) w_state_d = DRAIN;
                DRAIN:   if (w_fifo_empty) w_state_d = IDLE;
                default: w_state_d = IDLE;
            endcase
        end
    end

    // Two free words required: one ack may still arrive after sreq falls.
    always_comb begin
        w_sreq    = (r_state == RUN) && (w_fifo_level <= LW'(FIFO_DEPTH - 2));
        w_stoff_d = (w_state_d == IDLE) || (w_state_d == DRAIN);
    end

    always_ff @(posedge i_clk32 or negedge i_porb) begin
        if (!i_porb) begin
            r_ctrl    <= '0;
            r_start   <= '0;
            r_end     <= '0;
            r_cnt     <= '0;
            r_end_lat <= '0;
            r_sint    <= 1'b0;
            r_stoff   <= 1'b1;
        end else begin
            r_sint  <= w_frame_end || w_empty_frame;
            r_stoff <= w_stoff_d;
            if (w_wr_ctrl)   r_ctrl <= snd_ctrl_t'(i_reg_din[2:0]);
            if (w_sndon_clr) r_ctrl.sndon <= 1'b0;
            if (i_reg_we && w_in_start) begin
                case (w_pos)
                    POS_HI:  r_start[AW:16] <= i_reg_din[AW-16:0];
                    POS_MID: r_start[15:8]  <= i_reg_din;
                    POS_LO:  r_start[7:1]   <= i_reg_din[7:1];
                    default: ;
                endcase
            end
            if (i_reg_we && w_in_end) begin
                case (w_pos)
                    POS_HI:  r_end[AW:16] <= i_reg_din[AW-16:0];
                    POS_MID: r_end[15:8]  <= i_reg_din;
                    POS_LO:  r_end[7:1]   <= i_reg_din[7:1];
                    default: ;
                endcase
            end
            if (r_state == ARM) begin
                r_cnt     <= r_start;
                r_end_lat <= r_end;
            end else if (w_ack_run) begin
                if (w_frame_end && r_ctrl.rpt) begin
                    r_cnt     <= r_start;
                    r_end_lat <= r_end;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge i_clk32 or negedge i_porb) begin
        if (!i_porb) begin
            r_lo_next  <= 1'b0;
            r_sample_l <= '0;
            r_sample_r <= '0;
        end else if (w_abort) begin
            r_lo_next <= 1'b0;
        end else if (w_tick) begin
            if (r_ctrl.stereo) begin
                r_sample_l <= w_fifo_rdata[15:8];
                r_sample_r <= w_fifo_rdata[7:0];
                r_lo_next  <= 1'b0;
            end else if (r_lo_next) begin
                r_sample_l <= w_fifo_rdata[7:0];
                r_sample_r <= w_fifo_rdata[7:0];
                r_lo_next  <= 1'b0;
            end else begin
                r_sample_l <= w_fifo_rdata[15:8];
                r_sample_r <= w_fifo_rdata[15:8];
                r_lo_next  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_in_start)    w_rd_word = r_start;
        else if (w_in_cnt) w_rd_word = r_cnt;
        else if (w_in_end) w_rd_word = r_end;
        o_reg_dout = '0;
        case (w_pos)
            POS_HI:  o_reg_dout = 8'(w_rd_word[AW:16]);
            POS_MID: o_reg_dout = w_rd_word[15:8];
            POS_LO:  o_reg_dout = {w_rd_word[7:1], 1'b0};
            default: o_reg_dout = (i_reg_addr == REG_CTRL) ? {5'b0, r_ctrl} : 8'h00;
        endcase
    end

    snd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (16)
    ) u_fifo (
        .i_clk32 (i_clk32),
        .i_porb  (i_porb),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_wdata (i_dma_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign o_sreq     = w_sreq;
    assign o_snd_addr = r_cnt;
    assign o_sndon    = r_ctrl.sndon;
    assign o_stoff    = r_stoff;
    assign o_sint     = r_sint;
    assign o_sample_l = r_sample_l;
    assign o_sample_r = r_sample_r;

endmodule

// File: tb/tb_snd_dma_sequencer.sv
// Directed bench for snd_dma_sequencer: register vector table plus frame/playback sequences.
module tb_snd_dma_sequencer;
    import snd_dma_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned AW         = 21;

    logic          clk32       = 1'b0;
    logic          porb        = 1'b0;
    logic          reg_we      = 1'b0;
    logic [3:0]    reg_addr    = 4'd0;
    logic [7:0]    reg_din     = 8'd0;
    logic [7:0]    reg_dout;
    logic          dma_ack     = 1'b0;
    logic [15:0]   dma_data    = 16'd0;
    logic          sample_tick = 1'b0;
    logic          sreq;
    logic [AW:1]   snd_addr;
    logic          sndon;
    logic          stoff;
    logic          sint;
    logic [7:0]    sample_l;
    logic [7:0]    sample_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk32 = ~clk32;

    snd_dma_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .AW         (AW)
    ) dut (
        .i_clk32       (clk32),
        .i_porb        (porb),
        .i_reg_we      (reg_we),
        .i_reg_addr    (reg_addr),
        .i_reg_din     (reg_din),
        .o_reg_dout    (reg_dout),
        .i_dma_ack     (dma_ack),
        .i_dma_data    (dma_data),
        .i_sample_tick (sample_tick),
        .o_sreq        (sreq),
        .o_snd_addr    (snd_addr),
        .o_sndon       (sndon),
        .o_stoff       (stoff),
        .o_sint        (sint),
        .o_sample_l    (sample_l),
        .o_sample_r    (sample_r)
    );

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } reg_vec_t;

    reg_vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        reg_we   = 1'b1;
        reg_addr = a;
        reg_din  = d;
        step();
        reg_we   = 1'b0;
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp);
        reg_addr = a;
        #1;
        chk(name, 32'(reg_dout), 32'(exp));
    endtask

    task automatic set_addr(input logic [3:0] base, input logic [23:0] word);
        logic [23:0] b;
        b = word << 1;
        wr(base, b[23:16]);
        wr(base + 4'd1, b[15:8]);
        wr(base + 4'd2, b[7:0]);
    endtask

    task automatic tick_chk(input string name, input logic [7:0] el, input logic [7:0] er);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk({name, "_l"}, 32'(sample_l), 32'(el));
        chk({name, "_r"}, 32'(sample_r), 32'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] exp_addr;
        int n;

        vecs[0]  = '{1'b1, REG_START_HI,  8'hFF, 8'h3F};
        vecs[1]  = '{1'b1, REG_START_MID, 8'hA5, 8'hA5};
        vecs[2]  = '{1'b1, REG_START_LO,  8'h37, 8'h36};
        vecs[3]  = '{1'b1, REG_END_HI,    8'h12, 8'h12};
        vecs[4]  = '{1'b1, REG_END_MID,   8'h34, 8'h34};
        vecs[5]  = '{1'b1, REG_END_LO,    8'h57, 8'h56};
        vecs[6]  = '{1'b1, REG_CNT_HI,    8'h15, 8'h00};
        vecs[7]  = '{1'b1, REG_CNT_LO,    8'hFF, 8'h00};
        vecs[8]  = '{1'b0, 4'd10,         8'h00, 8'h00};
        vecs[9]  = '{1'b1, REG_CTRL,      8'h06, 8'h06};
        vecs[10] = '{1'b1, REG_CTRL,      8'h00, 8'h00};

        // Reset state
        repeat (3) @(posedge clk32);
        #1;
        chk("rst_sreq", 32'(sreq), 0);
        chk("rst_stoff", 32'(stoff), 1);
        chk("rst_sint", 32'(sint), 0);
        chk("rst_addr", 32'(snd_addr), 0);
        chk("rst_sample_l", 32'(sample_l), 0);
        chk("rst_sample_r", 32'(sample_r), 0);
        rd("rst_ctrl", REG_CTRL, 8'h00);
        rd("rst_start_lo", REG_START_LO, 8'h00);
        #2 porb = 1'b1;
        step();

        // Register table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].din);
            rd($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Single frame
        set_addr(REG_START_HI, 24'h000100);
        set_addr(REG_END_HI, 24'h000104);
        wr(REG_CTRL, 8'h01);
        chk("frm_arm_stoff", 32'(stoff), 0);
        step();
        chk("frm_run_sreq", 32'(sreq), 1);
        chk("frm_run_addr", 32'(snd_addr), 32'h100);
        for (int k = 0; k < 4; k++) begin
            dma_ack  = 1'b1;
            dma_data = {8'(8'h10 + k), 8'(8'h20 + k)};
            step();
            dma_ack  = 1'b0;
            chk($sformatf("frm_addr%0d", k), 32'(snd_addr), 32'(32'h101 + k));
            chk($sformatf("frm_sint%0d", k), 32'(sint), (k == 3) ? 1 : 0);
            if (k == 3) begin
                chk("frm_drain_stoff", 32'(stoff), 1);
                chk("frm_drain_sreq", 32'(sreq), 0);
            end
            step();
            chk($sformatf("frm_sint_clr%0d", k), 32'(sint), 0);
            step();
            step();
        end
        for (int k = 0; k < 4; k++) begin
            tick_chk($sformatf("frm_hi%0d", k), 8'(8'h10 + k), 8'(8'h10 + k));
            tick_chk($sformatf("frm_lo%0d", k), 8'(8'h20 + k), 8'(8'h20 + k));
        end
        step();
        rd("frm_done_ctrl", REG_CTRL, 8'h00);
        chk("frm_done_sndon", 32'(sndon), 0);
        chk("frm_done_stoff", 32'(stoff), 1);
        rd("frm_cnt_mid", REG_CNT_MID, 8'h02);
        rd("frm_cnt_lo", REG_CNT_LO, 8'h08);

        // Repeat frame, then abort with a simultaneous ack
        wr(REG_CTRL, 8'h03);
        step();
        exp_addr    = 24'h100;
        sample_tick = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dma_ack  = 1'b1;
            dma_data = 16'(16'h3000 + k);
            step();
            dma_ack  = 1'b0;
            exp_addr = exp_addr + 24'd1;
            if (exp_addr == 24'h104) exp_addr = 24'h100;
            chk($sformatf("rep_addr%0d", k), 32'(snd_addr), 32'(exp_addr));
            chk($sformatf("rep_sint%0d", k), 32'(sint), (k == 3 || k == 7) ? 1 : 0);
            chk($sformatf("rep_stoff%0d", k), 32'(stoff), 0);
            step();
            chk($sformatf("rep_sint_clr%0d", k), 32'(sint), 0);
            step();
            step();
        end
        sample_tick = 1'b0;
        chk("rep_addr_final", 32'(snd_addr), 32'h102);
        dma_ack = 1'b1;
        step();
        dma_ack = 1'b0;
        chk("abt_pre_addr", 32'(snd_addr), 32'h103);
        dma_ack = 1'b1;
        wr(REG_CTRL, 8'h00);
        chk("abt_stoff", 32'(stoff), 1);
        chk("abt_sreq", 32'(sreq), 0);
        chk("abt_sndon", 32'(sndon), 0);
        chk("abt_addr", 32'(snd_addr), 32'h103);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abt_late_addr%0d", k), 32'(snd_addr), 32'h103);
            chk($sformatf("abt_late_sreq%0d", k), 32'(sreq), 0);
        end
        dma_ack = 1'b0;

        // Empty frame
        set_addr(REG_START_HI, 24'h000200);
        set_addr(REG_END_HI, 24'h000200);
        wr(REG_CTRL, 8'h01);
        chk("emp_arm_sreq", 32'(sreq), 0);
        step();
        chk("emp_sint", 32'(sint), 1);
        chk("emp_sreq", 32'(sreq), 0);
        chk("emp_stoff", 32'(stoff), 1);
        rd("emp_ctrl", REG_CTRL, 8'h00);
        step();
        chk("emp_sint_clr", 32'(sint), 0);
        chk("emp_sreq_after", 32'(sreq), 0);

        // FIFO backpressure
        set_addr(REG_START_HI, 24'h000100);
        set_addr(REG_END_HI, 24'h000180);
        wr(REG_CTRL, 8'h01);
        step();
        n = 0;
        for (int c = 0; c < 20 && sreq; c++) begin
            dma_ack  = 1'b1;
            dma_data = {8'(8'h50 + n), 8'(n)};
            step();
            n++;
        end
        dma_ack = 1'b0;
        chk("bp_acks_to_drop", 32'(n), 3);
        chk("bp_sreq_low", 32'(sreq), 0);
        dma_ack  = 1'b1;
        dma_data = 16'h5303;
        step();
        chk("bp_full_addr", 32'(snd_addr), 32'h104);
        chk("bp_full_sreq", 32'(sreq), 0);
        dma_data = 16'hEEEE;
        step();
        dma_ack = 1'b0;
        chk("bp_ovf_addr", 32'(snd_addr), 32'h105);
        for (int k = 0; k < 4; k++) begin
            tick_chk($sformatf("bp_hi%0d", k), 8'(8'h50 + k), 8'(8'h50 + k));
            tick_chk($sformatf("bp_lo%0d", k), 8'(k), 8'(k));
        end
        tick_chk("bp_underrun", 8'h03, 8'h03);
        wr(REG_CTRL, 8'h00);

        // Mono then stereo playback of 0xA1B2
        set_addr(REG_START_HI, 24'h000300);
        set_addr(REG_END_HI, 24'h000301);
        wr(REG_CTRL, 8'h01);
        step();
        dma_ack  = 1'b1;
        dma_data = 16'hA1B2;
        step();
        dma_ack  = 1'b0;
        chk("mono_sint", 32'(sint), 1);
        chk("mono_addr", 32'(snd_addr), 32'h301);
        tick_chk("mono_b0", 8'hA1, 8'hA1);
        tick_chk("mono_b1", 8'hB2, 8'hB2);
        step();
        rd("mono_ctrl", REG_CTRL, 8'h00);
        tick_chk("mono_hold", 8'hB2, 8'hB2);

        wr(REG_CTRL, 8'h05);
        step();
        dma_ack  = 1'b1;
        dma_data = 16'hA1B2;
        step();
        dma_ack  = 1'b0;
        tick_chk("st_word", 8'hA1, 8'hB2);
        step();
        rd("st_ctrl", REG_CTRL, 8'h04);
        tick_chk("st_hold", 8'hA1, 8'hB2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
